// File: rtl/data_sram_bridge.sv
// Bridges a single-cycle SRAM-style CPU data port onto a req/addr_ok/data_ok memory bus,
// stalling the CPU until the response arrives or a response timeout aborts the access.
module data_sram_bridge #(
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_RDATA   = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state_reg;
    logic [3:0]  wen_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic [15:0] tmo_cnt_reg;
    logic        bus_err_reg;

    logic        is_wr;
    logic [1:0]  enc_size;
    logic [1:0]  enc_lo;

    assign is_wr = |wen_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            wen_reg     <= 4'd0;
            addr_reg    <= 32'd0;
            wdata_reg   <= 32'd0;
            rdata_reg   <= 32'd0;
            tmo_cnt_reg <= 16'd0;
            bus_err_reg <= 1'b0;
        end else begin
            bus_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cpu_en) begin
                        wen_reg   <= cpu_wen;
                        addr_reg  <= cpu_addr;
                        wdata_reg <= cpu_wdata;
                        state_reg <= WAIT_ADDR;
                    end
                end
                WAIT_ADDR: begin
                    // data_ok arriving alongside addr_ok is deliberately not looked at here
                    if (mem_addr_ok) begin
                        tmo_cnt_reg <= 16'd0;
                        state_reg   <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (mem_data_ok) begin
                        if (!is_wr) begin
                            rdata_reg <= mem_rdata;
                        end
                        state_reg <= DONE;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        bus_err_reg <= 1'b1;
                        if (!is_wr) begin
                            rdata_reg <= ERR_RDATA;
                        end
                        state_reg <= DONE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Strobe pattern selects transfer size and the low address bits; odd patterns fall back to a word write.
    always_comb begin
        enc_size = 2'd2;
        enc_lo   = 2'b00;
        if (is_wr) begin
            case (wen_reg)
                4'b0011: begin enc_size = 2'd1; enc_lo = 2'b00; end
                4'b1100: begin enc_size = 2'd1; enc_lo = 2'b10; end
                4'b0001: begin enc_size = 2'd0; enc_lo = 2'b00; end
                4'b0010: begin enc_size = 2'd0; enc_lo = 2'b01; end
                4'b0100: begin enc_size = 2'd0; enc_lo = 2'b10; end
                4'b1000: begin enc_size = 2'd0; enc_lo = 2'b11; end
                default: begin enc_size = 2'd2; enc_lo = 2'b00; end
            endcase
        end
    end

    always_comb begin
        cpu_stall = 1'b1;
        case (state_reg)
            IDLE:    cpu_stall = cpu_en;
            DONE:    cpu_stall = 1'b0;
            default: cpu_stall = 1'b1;
        endcase
    end

    assign mem_req   = (state_reg == WAIT_ADDR);
    assign mem_wr    = mem_req & is_wr;
    assign mem_size  = mem_req ? enc_size : 2'd0;
    assign mem_addr  = mem_req ? {addr_reg[31:2], enc_lo} : 32'd0;
    assign mem_wdata = mem_req ? wdata_reg : 32'd0;
    assign cpu_rdata = rdata_reg;
    assign bus_err   = bus_err_reg;

endmodule
